// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the ordered reset-release sequencer.
package reset_sequencer_pkg;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_HOLD,
        ST_WAIT_DONE,
        ST_READY,
        ST_FAULT
    } seq_state_t;

    // Convert a duration in ns to whole clock cycles, never less than one.
    function automatic int unsigned cycles_of(input int unsigned ns, input int unsigned period);
        int unsigned c;
        c = ns / period;
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/sync_level.sv
// Two-flop level synchronizer for quasi-static asynchronous inputs.
module sync_level
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] meta;
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync;

    // Two back-to-back flops resolve metastability before use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;

endmodule

// File: rtl/reset_sequencer.sv
// Releases downstream stage resets one at a time, waiting for each stage's
// done before moving on; retries a stage on timeout and latches a fault when
// the retries are exhausted.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter  int unsigned NUM_STAGES      = 3,
    parameter  int unsigned CLK_PERIOD_NS   = 10,
    parameter  int unsigned STAGE_HOLD_NS   = 1000,
    parameter  int unsigned DONE_TIMEOUT_NS = 1000000,
    parameter  int unsigned MAX_RETRY       = 2,
    localparam int unsigned IDX_W           = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sys_reset_in,
    input  logic [NUM_STAGES-1:0] stage_done_in,
    output logic [NUM_STAGES-1:0] stage_reset_out,
    output logic                  all_ready_out,
    output logic                  fault_out,
    output logic [IDX_W-1:0]      fault_stage_out
);

    localparam int unsigned HOLD_CYCLES    = cycles_of(STAGE_HOLD_NS, CLK_PERIOD_NS);
    localparam int unsigned TIMEOUT_CYCLES = cycles_of(DONE_TIMEOUT_NS, CLK_PERIOD_NS);
    localparam int unsigned HOLD_W         = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned TMO_W          = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RETRY_W        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
    // Timeout is loaded one short so that expiry at zero lands on the last
    // of exactly TIMEOUT_CYCLES WAIT_DONE cycles.
    localparam logic [TMO_W-1:0]   TMO_LOAD  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_STAGES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    seq_state_t state, state_next;

    logic [NUM_STAGES-1:0] done_s;
    logic [IDX_W-1:0]      idx, idx_next;
    logic [RETRY_W-1:0]    retry, retry_next;
    logic [HOLD_W-1:0]     hold_cnt, hold_next;
    logic [TMO_W-1:0]      tmo_cnt, tmo_next;
    logic [NUM_STAGES-1:0] resets_next;
    logic                  ready_next;
    logic                  fault_next;
    logic [IDX_W-1:0]      fstage_next;

    logic done_cur;
    logic last_stage;
    logic hold_zero;
    logic tmo_zero;
    logic retry_left;
    logic done_lost;

    sync_level #(
        .WIDTH(NUM_STAGES)
    ) u_done_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (stage_done_in),
        .q    (done_s)
    );

    assign done_cur   = done_s[idx];
    assign last_stage = (idx == LAST_IDX);
    assign hold_zero  = (hold_cnt == '0);
    assign tmo_zero   = (tmo_cnt == '0);
    assign retry_left = (retry < RETRY_MAX);
    assign done_lost  = ~&done_s;

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_ASSERT;
            idx             <= '0;
            retry           <= '0;
            hold_cnt        <= '0;
            tmo_cnt         <= '0;
            stage_reset_out <= '1;
            all_ready_out   <= 1'b0;
            fault_out       <= 1'b0;
            fault_stage_out <= '0;
        end else begin
            state           <= state_next;
            idx             <= idx_next;
            retry           <= retry_next;
            hold_cnt        <= hold_next;
            tmo_cnt         <= tmo_next;
            stage_reset_out <= resets_next;
            all_ready_out   <= ready_next;
            fault_out       <= fault_next;
            fault_stage_out <= fstage_next;
        end
    end

    // Next-state selection; sys_reset_in overrides every transition.
    always_comb begin
        state_next = state;
        if (sys_reset_in) begin
            state_next = ST_ASSERT;
        end else begin
            case (state)
                ST_ASSERT:    state_next = ST_HOLD;
                ST_HOLD:      if (hold_zero) state_next = ST_WAIT_DONE;
                ST_WAIT_DONE: begin
                    if (done_cur) begin
                        state_next = last_stage ? ST_READY : ST_HOLD;
                    end else if (tmo_zero) begin
                        state_next = retry_left ? ST_HOLD : ST_FAULT;
                    end
                end
                ST_READY:     if (done_lost) state_next = ST_HOLD;
                ST_FAULT:     state_next = ST_FAULT;
                default:      state_next = ST_ASSERT;
            endcase
        end
    end

    // Next values for counters, stage index and the registered outputs.
    always_comb begin
        idx_next    = idx;
        retry_next  = retry;
        hold_next   = hold_cnt;
        tmo_next    = tmo_cnt;
        resets_next = stage_reset_out;
        ready_next  = all_ready_out;
        fault_next  = fault_out;
        fstage_next = fault_stage_out;
        if (sys_reset_in) begin
            idx_next    = '0;
            retry_next  = '0;
            resets_next = '1;
            ready_next  = 1'b0;
            fault_next  = 1'b0;
            fstage_next = '0;
        end else begin
            case (state)
                ST_ASSERT: hold_next = HOLD_LOAD;
                ST_HOLD: begin
                    if (hold_zero) begin
                        resets_next[idx] = 1'b0;
                        tmo_next         = TMO_LOAD;
                    end else begin
                        hold_next = hold_cnt - 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (done_cur) begin
                        if (last_stage) begin
                            ready_next = 1'b1;
                        end else begin
                            idx_next   = idx + 1'b1;
                            retry_next = '0;
                            hold_next  = HOLD_LOAD;
                        end
                    end else if (tmo_zero) begin
                        resets_next[idx] = 1'b1;
                        if (retry_left) begin
                            retry_next = retry + 1'b1;
                            hold_next  = HOLD_LOAD;
                        end else begin
                            fault_next  = 1'b1;
                            fstage_next = idx;
                        end
                    end else begin
                        tmo_next = tmo_cnt - 1'b1;
                    end
                end
                ST_READY: begin
                    if (done_lost) begin
                        resets_next = '1;
                        ready_next  = 1'b0;
                        idx_next    = '0;
                        retry_next  = '0;
                        hold_next   = HOLD_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus random
// per-stage done response times checked against an event-time model.
module tb_reset_sequencer;

    localparam int N     = 3;
    localparam int H     = 10;
    localparam int T     = 50;
    localparam int MAXR  = 2;
    localparam int NEVER = 1000000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sys_reset_in = 1'b1;
    logic [N-1:0]   stage_done_in = '0;
    logic [N-1:0]   stage_reset_out;
    logic           all_ready_out;
    logic           fault_out;
    logic [1:0]     fault_stage_out;

    int checks = 0;
    int errors = 0;

    // Model inputs/outputs: per-stage response delay after first release,
    // and the derived release windows, ready edge and fault edge.
    int resp [N];
    int tin  [N];
    int n_att[N];
    int rel  [N][MAXR+1];
    int fin  [N][MAXR+1];
    int ready_at;
    int fault_at;
    int fault_idx;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_STAGES     (3),
        .CLK_PERIOD_NS  (10),
        .STAGE_HOLD_NS  (100),
        .DONE_TIMEOUT_NS(500),
        .MAX_RETRY      (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sys_reset_in   (sys_reset_in),
        .stage_done_in  (stage_done_in),
        .stage_reset_out(stage_reset_out),
        .all_ready_out  (all_ready_out),
        .fault_out      (fault_out),
        .fault_stage_out(fault_stage_out)
    );

    // Edge 0 is the first edge sampling sys_reset_in low. A stage released at
    // edge R has its done input visible at edge tin; the sequencer reacts two
    // synchronizer edges later, and must react by R+T or the attempt times out.
    task automatic plan_sequence();
        int  t;
        int  a;
        bit  stop;
        ready_at  = NEVER;
        fault_at  = NEVER;
        fault_idx = 0;
        for (int s = 0; s < N; s++) begin
            n_att[s] = 0;
            tin[s]   = NEVER;
        end
        t    = H + 1;
        stop = 1'b0;
        for (int s = 0; s < N; s++) begin
            if (!stop) begin
                for (int att = 0; att <= MAXR; att++) begin
                    rel[s][att] = t;
                    fin[s][att] = NEVER;
                    n_att[s]    = att + 1;
                    if (att == 0 && resp[s] != NEVER) tin[s] = t + resp[s];
                    if (tin[s] == NEVER) a = NEVER;
                    else a = (t + 1 > tin[s] + 2) ? t + 1 : tin[s] + 2;
                    if (a <= t + T) begin
                        if (s == N - 1) ready_at = a;
                        else t = a + H + 1;
                        break;
                    end
                    fin[s][att] = t + T;
                    if (att == MAXR) begin
                        fault_at  = t + T;
                        fault_idx = s;
                        stop      = 1'b1;
                    end else begin
                        t = t + T + H + 1;
                    end
                end
            end
        end
    endtask

    function automatic logic [N-1:0] exp_resets(input int e);
        logic [N-1:0] v;
        v = '1;
        for (int s = 0; s < N; s++)
            for (int att = 0; att < n_att[s]; att++)
                if (e >= rel[s][att] && e < fin[s][att]) v[s] = 1'b0;
        return v;
    endfunction

    // Holds sys_reset_in for pre cycles, then releases it and checks every
    // edge against the planned event times until the sequence settles.
    task automatic run_sequence(input string name, input int pre);
        int           last;
        logic [N-1:0] er;
        logic         eready;
        logic         efault;
        plan_sequence();
        sys_reset_in  = 1'b1;
        stage_done_in = '0;
        for (int i = 0; i < pre; i++) begin
            @(posedge clk); #1;
            checks++;
            if (stage_reset_out !== '1 || all_ready_out !== 1'b0 || fault_out !== 1'b0) begin
                errors++;
                $display("FAIL %s in_reset: resets=%b ready=%b fault=%b, required 111/0/0",
                         name, stage_reset_out, all_ready_out, fault_out);
            end
        end
        sys_reset_in = 1'b0;
        last = ((ready_at != NEVER) ? ready_at : fault_at) + 8;
        for (int e = 0; e <= last; e++) begin
            @(posedge clk); #1;
            er     = exp_resets(e);
            eready = (e >= ready_at);
            efault = (e >= fault_at);
            checks++;
            if (stage_reset_out !== er) begin
                errors++;
                $display("FAIL %s stage_reset_out edge %0d: got %b, required %b", name, e, stage_reset_out, er);
            end
            checks++;
            if (all_ready_out !== eready) begin
                errors++;
                $display("FAIL %s all_ready_out edge %0d: got %b, required %b", name, e, all_ready_out, eready);
            end
            checks++;
            if (fault_out !== efault) begin
                errors++;
                $display("FAIL %s fault_out edge %0d: got %b, required %b", name, e, fault_out, efault);
            end
            if (efault) begin
                checks++;
                if (fault_stage_out !== 2'(fault_idx)) begin
                    errors++;
                    $display("FAIL %s fault_stage_out edge %0d: got %0d, required %0d", name, e, fault_stage_out, fault_idx);
                end
            end
            for (int s = 0; s < N; s++) stage_done_in[s] = (tin[s] <= e + 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sys_reset_in = 1'b1;
        stage_done_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (stage_reset_out !== 3'b111 || all_ready_out !== 1'b0 || fault_out !== 1'b0 || fault_stage_out !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: resets=%b ready=%b fault=%b fstage=%0d, required 111/0/0/0",
                     stage_reset_out, all_ready_out, fault_out, fault_stage_out);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (stage_reset_out !== 3'b111) begin
            errors++;
            $display("FAIL reset_release: resets=%b, required 111", stage_reset_out);
        end
    endtask

    task automatic test_nominal();
        resp = '{5, 5, 5};
        run_sequence("nominal", 3);
    endtask

    task automatic test_single_retry();
        resp = '{5, 60, 5};
        run_sequence("single_retry", 3);
    endtask

    task automatic test_timeout_boundary();
        // 48: done seen in the final timeout cycle; 49: one cycle too late.
        resp = '{48, 49, 3};
        run_sequence("timeout_boundary", 3);
    endtask

    task automatic test_fault();
        resp = '{5, 5, NEVER};
        run_sequence("fault", 3);
    endtask

    task automatic test_restart_from_fault();
        checks++;
        if (fault_out !== 1'b1 || stage_reset_out !== 3'b100) begin
            errors++;
            $display("FAIL restart_precondition: fault=%b resets=%b, required 1/100", fault_out, stage_reset_out);
        end
        resp = '{5, 5, 5};
        run_sequence("restart_from_fault", 1);
    endtask

    task automatic test_ready_loss();
        logic [N-1:0] er;
        logic         eready;
        resp = '{5, 5, 5};
        run_sequence("ready_loss_pre", 3);
        stage_done_in[0] = 1'b0;
        for (int j = 0; j <= H + 4; j++) begin
            @(posedge clk); #1;
            er     = (j < 2) ? 3'b000 : ((j >= H + 3) ? 3'b110 : 3'b111);
            eready = (j < 2);
            checks++;
            if (stage_reset_out !== er || all_ready_out !== eready) begin
                errors++;
                $display("FAIL ready_loss edge +%0d: resets=%b ready=%b, required %b/%b",
                         j, stage_reset_out, all_ready_out, er, eready);
            end
        end
    endtask

    task automatic test_async_reset();
        sys_reset_in  = 1'b1;
        stage_done_in = '0;
        repeat (3) @(posedge clk);
        #1;
        sys_reset_in = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (stage_reset_out !== 3'b110) begin
            errors++;
            $display("FAIL async_pre_wait: resets=%b, required 110", stage_reset_out);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (stage_reset_out !== 3'b111 || all_ready_out !== 1'b0 || fault_out !== 1'b0 || fault_stage_out !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: resets=%b ready=%b fault=%b fstage=%0d, required 111/0/0/0",
                     stage_reset_out, all_ready_out, fault_out, fault_stage_out);
        end
        @(posedge clk); #1;
        checks++;
        if (stage_reset_out !== 3'b111) begin
            errors++;
            $display("FAIL async_reset_held: resets=%b, required 111", stage_reset_out);
        end
        sys_reset_in = 1'b1;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (stage_reset_out !== 3'b111 || fault_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_exit: resets=%b fault=%b, required 111/0", stage_reset_out, fault_out);
        end
    endtask

    task automatic test_random();
        int r;
        for (int it = 0; it < 6; it++) begin
            for (int s = 0; s < N; s++) begin
                r = int'($urandom_range(0, 9));
                if (r < 6)      resp[s] = int'($urandom_range(1, 48));
                else if (r < 9) resp[s] = int'($urandom_range(49, 160));
                else            resp[s] = NEVER;
            end
            run_sequence($sformatf("random%0d", it), int'($urandom_range(1, 4)));
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_single_retry();
        test_timeout_boundary();
        test_fault();
        test_restart_from_fault();
        test_ready_loss();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
